// File: rtl/jkff_pkg.sv
// jkff_pkg: shared definitions for the JK flip-flop driver.
//
// Contents:
//   JK_HOLD / JK_RESET / JK_SET / JK_TOGGLE : jk[1:0] excitation codes, with jk[1]=J and jk[0]=K
//   state_t   : driver FSM states (IDLE, APPLY, CHECK)
//   jk_excite : the excitation that moves the current q to a wanted value
//
// Build option:
//   JK_TOGGLE_EN : when defined, a change of q is requested with the toggle
//                  code (11). Otherwise the set/reset codes are used and 11 is
//                  never produced.
package jkff_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Excitation that takes a JK flip-flop from q to exp_bit on its next edge.
    function automatic logic [1:0] jk_excite(input logic q, input logic exp_bit);
        if (q == exp_bit) begin
            return JK_HOLD;
        end
`ifdef JK_TOGGLE_EN
        return JK_TOGGLE;
`else
        return exp_bit ? JK_SET : JK_RESET;
`endif
    endfunction

endpackage

// File: rtl/jk_tgt_fifo.sv
// jk_tgt_fifo: DEPTH x 1-bit synchronous FIFO holding the target bits.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous, active-high reset (empties the FIFO)
//   push   in   write din this cycle
//   pop    in   consume the head this cycle
//   din    in   bit to write
//   dout   out  head of the FIFO; equals din while the FIFO is empty
//   full   out  DEPTH entries held
//   empty  out  no entries held
//
// Push and pop in the same cycle are accepted at any occupancy: when full,
// the pop frees the slot the push needs; when empty, the pushed bit passes
// straight through to dout and is consumed in the same cycle.
module jk_tgt_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // A pop on an empty FIFO is only honoured alongside a push (pass-through).
    assign do_pop  = pop & (~empty | push);
    assign do_push = push & (~full | do_pop);

    assign dout = empty ? din : mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jkff_driver.sv
// jkff_driver: drives the jk input of an external JK flip-flop so that its q
// output follows a buffered stream of target bits, and checks the result.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   tgt_valid  in   target bit offered
//   tgt_bit    in   desired next q value
//   tgt_ready  out  FIFO can accept (not full)
//   jk[1:0]    out  registered excitation, jk[1]=J, jk[0]=K
//   q          in   flip-flop true output
//   qb         in   flip-flop complement output
//   busy       out  FSM not idle, or target bits still queued
//   done       out  one-cycle pulse after the last queued bit is checked
//   err        out  sticky mismatch flag
//   err_cnt    out  saturating mismatch count (ERR_W bits)
//
// Each target bit takes two cycles: APPLY drives the excitation for one
// cycle (the flip-flop captures at its end), CHECK compares q with the target
// and also flags q==qb as a broken complement pair.
//
// Build option:
//   JK_TOGGLE_EN : request changes of q with the toggle code (see jkff_pkg).
module jkff_driver
    import jkff_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    output logic [1:0]       jk,
    input  logic             q,
    input  logic             qb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    state_t     state;
    state_t     state_next;
    logic       exp_bit;
    logic       exp_next;
    logic [1:0] jk_next;
    logic       done_next;
    logic       mismatch;

    logic fifo_push;
    logic fifo_pop;
    logic fifo_dout;
    logic fifo_full;
    logic fifo_empty;

    jk_tgt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (tgt_bit),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tgt_ready = ~fifo_full;
    assign fifo_push = tgt_valid & tgt_ready;
    assign busy      = (state != IDLE) | ~fifo_empty;
    assign mismatch  = (q != exp_bit) | (q == qb);

    // jk is registered: the excitation for a bit is loaded on the edge that
    // enters APPLY, so it is stable for the whole APPLY cycle.
    always_comb begin
        state_next = state;
        exp_next   = exp_bit;
        jk_next    = JK_HOLD;
        done_next  = 1'b0;
        fifo_pop   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = APPLY;
                end
            end
            APPLY: begin
                state_next = CHECK;
            end
            CHECK: begin
                // A push landing in this same cycle keeps the stream going;
                // the FIFO hands that bit straight through if it was empty.
                if (!fifo_empty || fifo_push) begin
                    fifo_pop   = 1'b1;
                    state_next = APPLY;
                end else begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (fifo_pop) begin
            exp_next = fifo_dout;
            jk_next  = jk_excite(q, fifo_dout);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            exp_bit <= 1'b0;
            jk      <= JK_HOLD;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            exp_bit <= exp_next;
            jk      <= jk_next;
            done    <= done_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (state == CHECK && mismatch) begin
            err <= 1'b1;
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_jkff_driver.sv
// tb_jkff_driver: directed, self-checking bench for jkff_driver.
// A behavioural JK flip-flop closes the loop; its outputs can be overridden
// (stuck q, or q==qb) to provoke mismatches. Expected jk values are queued as
// each target bit is accepted and compared as the driver applies them.
module tb_jkff_driver;

    localparam int unsigned DEPTH = 8;

    logic       clk;
    logic       rst;
    logic       tgt_valid;
    logic       tgt_bit;
    logic       tgt_ready;
    logic [1:0] jk;
    logic       q;
    logic       qb;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] err_cnt;

    logic       tgt_valid2;
    logic       tgt_bit2;
    logic       tgt_ready2;
    logic [1:0] jk2;
    logic       busy2;
    logic       done2;
    logic       err2;
    logic [1:0] err_cnt2;

    // 0: healthy flip-flop, 1: q stuck at 0 (qb=1), 2: q=qb=1
    int unsigned mode;
    logic        model_q;

    int unsigned errors;
    int unsigned checks;
    int unsigned done_cnt;
    int unsigned accepted;
    bit          low_seen;
    int unsigned max_low;

    logic       bits [$];
    logic [1:0] sb   [$];

    jkff_driver #(
        .DEPTH (DEPTH),
        .ERR_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_bit   (tgt_bit),
        .tgt_ready (tgt_ready),
        .jk        (jk),
        .q         (q),
        .qb        (qb),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    // Narrow counter instance with a permanently stuck flip-flop.
    jkff_driver #(
        .DEPTH (DEPTH),
        .ERR_W (2)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid2),
        .tgt_bit   (tgt_bit2),
        .tgt_ready (tgt_ready2),
        .jk        (jk2),
        .q         (1'b0),
        .qb        (1'b1),
        .busy      (busy2),
        .done      (done2),
        .err       (err2),
        .err_cnt   (err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q <= 1'b0;
        end else begin
            case (jk)
                2'b01:   model_q <= 1'b0;
                2'b10:   model_q <= 1'b1;
                2'b11:   model_q <= ~model_q;
                default: model_q <= model_q;
            endcase
        end
    end

    assign q  = (mode == 0) ? model_q  : (mode == 1) ? 1'b0 : 1'b1;
    assign qb = (mode == 0) ? ~model_q : 1'b1;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int unsigned m);
        rst        = 1'b1;
        tgt_valid  = 1'b0;
        tgt_bit    = 1'b0;
        tgt_valid2 = 1'b0;
        tgt_bit2   = 1'b0;
        mode       = m;
        cyc();
        rst = 1'b0;
    endtask

    // Expected excitation from the JK truth table.
    function automatic logic [1:0] exc(input logic qv, input logic b);
        if (qv == b) return 2'b00;
`ifdef JK_TOGGLE_EN
        return 2'b11;
`else
        return b ? 2'b10 : 2'b01;
`endif
    endfunction

    function automatic logic q_after(input int unsigned m, input logic b);
        if (m == 1) return 1'b0;
        if (m == 2) return 1'b1;
        return b;
    endfunction

    // Offers bits[] back-to-back from an idle, empty driver and compares jk
    // every cycle from the first APPLY until every accepted bit is checked.
    task automatic run_stream(input string tag);
        int unsigned idx;
        int unsigned edges;
        int unsigned low_run;
        int unsigned guard;
        logic        acc;
        logic        qm;
        logic [1:0]  exp_jk;
        idx      = 0;
        edges    = 0;
        low_run  = 0;
        guard    = 0;
        accepted = 0;
        low_seen = 1'b0;
        max_low  = 0;
        qm       = q;
        tgt_valid = 1'b1;
        tgt_bit   = bits[0];
        while ((idx < bits.size() || sb.size() > 0) && guard < 400) begin
            acc = tgt_valid & tgt_ready;
            if (acc) begin
                sb.push_back(exc(qm, tgt_bit));
                sb.push_back(2'b00);
                qm = q_after(mode, tgt_bit);
                accepted++;
            end
            cyc();
            edges++;
            guard++;
            if (acc) begin
                idx++;
                if (idx < bits.size()) tgt_bit = bits[idx];
                else tgt_valid = 1'b0;
            end
            if (edges >= 2 && sb.size() > 0) begin
                exp_jk = sb.pop_front();
                check({tag, "_jk"}, 32'(jk), 32'(exp_jk));
            end
            if (tgt_ready) begin
                low_run = 0;
            end else begin
                low_run++;
                low_seen = 1'b1;
                if (low_run > max_low) max_low = low_run;
            end
        end
        if (guard >= 400) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed=%0d cycles expected=<400", tag, guard);
            sb.delete();
        end
    endtask

    task automatic finish_stream(input string tag, input int unsigned dc0);
        cyc();
        check({tag, "_done_hi"}, 32'(done), 32'd1);
        cyc();
        check({tag, "_done_lo"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_once"}, done_cnt - dc0, 32'd1);
    endtask

    initial begin
        int unsigned dc0;
        errors     = 0;
        checks     = 0;
        done_cnt   = 0;
        mode       = 0;
        rst        = 1'b1;
        tgt_valid  = 1'b0;
        tgt_bit    = 1'b0;
        tgt_valid2 = 1'b0;
        tgt_bit2   = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_jk", 32'(jk), 32'd0);
        check("rst_ready", 32'(tgt_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_errcnt", 32'(err_cnt), 32'd0);
        check("rst_errcnt2", 32'(err_cnt2), 32'd0);
        rst = 1'b0;

        // 1,0,1,1 through a healthy flip-flop
        bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        dc0 = done_cnt;
        run_stream("basic");
        finish_stream("basic", dc0);
        check("basic_err", 32'(err), 32'd0);
        check("basic_errcnt", 32'(err_cnt), 32'd0);

        // Sustained offer: the 1-per-2-cycle drain falls behind, so the FIFO
        // fills and tgt_ready toggles with each pop.
        do_reset(0);
        bits.delete();
        for (int i = 0; i < 2 * DEPTH + 4; i++) bits.push_back(1'($urandom_range(0, 1)));
        dc0 = done_cnt;
        run_stream("burst");
        check("burst_accepted", accepted, 2 * DEPTH + 4);
        check("burst_ready_dropped", 32'(low_seen), 32'd1);
        check("burst_ready_rerise", 32'(max_low <= 2), 32'd1);
        finish_stream("burst", dc0);
        check("burst_err", 32'(err), 32'd0);

        // q stuck at 0, targets 1,1,1
        do_reset(1);
        bits = '{1'b1, 1'b1, 1'b1};
        run_stream("stuck");
        cyc();
        check("stuck_err", 32'(err), 32'd1);
        check("stuck_errcnt", 32'(err_cnt), 32'd3);

        // q == qb == 1 with target 1: only the complement check fires
        do_reset(2);
        bits = '{1'b1};
        run_stream("compl");
        cyc();
        check("compl_err", 32'(err), 32'd1);
        check("compl_errcnt", 32'(err_cnt), 32'd1);

        // 2-bit counter saturates at 3 after six mismatches
        do_reset(0);
        tgt_valid2 = 1'b1;
        tgt_bit2   = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        tgt_valid2 = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        check("sat_err", 32'(err2), 32'd1);
        check("sat_errcnt", 32'(err_cnt2), 32'd3);
        check("sat_busy", 32'(busy2), 32'd0);

        // Reset during APPLY with 4 bits still queued
        do_reset(0);
        tgt_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tgt_bit = 1'((i + 1) % 2);
            cyc();
        end
        tgt_valid = 1'b0;
        check("midrst_pre_jk", 32'(jk), 32'(exc(1'b1, 1'b0)));
        check("midrst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_jk", 32'(jk), 32'd0);
        check("midrst_ready", 32'(tgt_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dc0 = done_cnt;
        for (int i = 0; i < 6; i++) cyc();
        check("midrst_post_busy", 32'(busy), 32'd0);
        check("midrst_post_jk", 32'(jk), 32'd0);
        check("midrst_no_done", done_cnt - dc0, 32'd0);

        // 1,0 from q=0 (toggle codes when JK_TOGGLE_EN is defined)
        do_reset(0);
        bits = '{1'b1, 1'b0};
        dc0 = done_cnt;
        run_stream("tog");
        finish_stream("tog", dc0);
        check("tog_err", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
